// File: rtl/cam_init_seq.sv
// Camera init sequencer: walks a register init table once per camera and issues
// I2C register writes, with table-encoded delays and bounded NACK retries.
module cam_init_seq #(
  parameter int         NUM_ENTRIES = 56,
  parameter int         NUM_CAMS    = 2,
  parameter logic [7:0] SLAVE_ADDR  = 8'h10,
  parameter int         MAX_RETRY   = 3,
  parameter int         DLY_TICKS   = 400,
  localparam int        AW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  localparam int        CW = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1
) (
  input  logic                clk400,
  input  logic                reset,
  input  logic                init,
  output logic [AW-1:0]       tbl_addr,
  input  logic [23:0]         tbl_data,
  output logic [CW-1:0]       cam_sel,
  output logic                i2c_req,
  output logic [7:0]          i2c_slave,
  output logic [15:0]         i2c_reg,
  output logic [7:0]          i2c_data,
  input  logic                i2c_done,
  input  logic                i2c_nack,
  output logic [NUM_CAMS-1:0] cam_ready,
  output logic                busy,
  output logic                error
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, ISSUE, WAIT, DELAY, NEXT, DONE, ERR
  } state_t;

  state_t        state, state_nxt;
  logic          init_p1;
  logic [AW-1:0] entry;
  logic [RW-1:0] retry;
  logic [23:0]   dly_cnt;
  logic          start, last_entry, last_cam, retry_ok, is_delay, zero_delay;

  function automatic logic [23:0] delay_ticks(input logic [7:0] units);
    return 24'(units) * 24'(DLY_TICKS);
  endfunction

  // init_p1 resets high so a level held across reset is not taken as a start
  assign start      = init && !init_p1 && (state == IDLE || state == DONE || state == ERR);
  assign last_entry = (entry == AW'(NUM_ENTRIES - 1));
  assign last_cam   = (cam_sel == CW'(NUM_CAMS - 1));
  assign retry_ok   = (retry < RW'(MAX_RETRY));
  assign is_delay   = (tbl_data[23:8] == 16'hFFFF);
  assign zero_delay = (tbl_data[7:0] == 8'd0);
  assign tbl_addr   = entry;
  assign i2c_slave  = SLAVE_ADDR;

  always_ff @(posedge clk400) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    i2c_req   = 1'b0;
    busy      = 1'b1;
    error     = 1'b0;
    case (state)
      IDLE, DONE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      ERR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) state_nxt = FETCH;
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        if (!is_delay)       state_nxt = ISSUE;
        else if (zero_delay) state_nxt = NEXT;
        else                 state_nxt = DELAY;
      end
      ISSUE: begin
        i2c_req   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (i2c_done) begin
          if (!i2c_nack)     state_nxt = NEXT;
          else if (retry_ok) state_nxt = ISSUE;
          else               state_nxt = ERR;
        end
      end
      DELAY: if (dly_cnt == 24'd0) state_nxt = NEXT;
      NEXT: begin
        if (!last_entry || !last_cam) state_nxt = FETCH;
        else                          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sequencing control: entry/camera walk, retries, delay count, completion flags
  always_ff @(posedge clk400) begin
    if (reset) begin
      init_p1   <= 1'b1;
      entry     <= '0;
      cam_sel   <= '0;
      retry     <= '0;
      dly_cnt   <= '0;
      cam_ready <= '0;
    end else begin
      init_p1 <= init;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            entry     <= '0;
            cam_sel   <= '0;
            retry     <= '0;
            cam_ready <= '0;
          end
        end
        LOAD: if (is_delay && !zero_delay) dly_cnt <= delay_ticks(tbl_data[7:0]) - 24'd1;
        WAIT: begin
          if (i2c_done) begin
            if (!i2c_nack)     retry <= '0;
            else if (retry_ok) retry <= retry + 1'b1;
          end
        end
        DELAY: if (dly_cnt != 24'd0) dly_cnt <= dly_cnt - 24'd1;
        NEXT: begin
          if (!last_entry) begin
            entry <= entry + 1'b1;
          end else begin
            cam_ready[cam_sel] <= 1'b1;
            if (!last_cam) begin
              cam_sel <= cam_sel + 1'b1;
              entry   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // write operands: captured from the table word, held through retries
  always_ff @(posedge clk400) begin
    if (state == LOAD) begin
      i2c_reg  <= tbl_data[23:8];
      i2c_data <= tbl_data[7:0];
    end
  end

endmodule

// File: tb/tb_cam_init_seq.sv
// Directed bench for cam_init_seq: table-driven scenarios against an I2C responder
// model and a registered init-table ROM, plus a hand-written reset-in-WAIT sequence.
module tb_cam_init_seq;
  localparam int         NE = 4;
  localparam int         NC = 2;
  localparam int         MR = 3;
  localparam int         DT = 400;
  localparam logic [7:0] SA = 8'h10;

  logic        clk400 = 1'b0;
  logic        reset, init;
  logic [1:0]  tbl_addr;
  logic [23:0] tbl_data;
  logic [0:0]  cam_sel;
  logic        i2c_req;
  logic [7:0]  i2c_slave;
  logic [15:0] i2c_reg;
  logic [7:0]  i2c_data;
  logic        i2c_done, i2c_nack;
  logic [1:0]  cam_ready;
  logic        busy, error;

  cam_init_seq #(
    .NUM_ENTRIES(NE), .NUM_CAMS(NC), .SLAVE_ADDR(SA), .MAX_RETRY(MR), .DLY_TICKS(DT)
  ) dut (
    .clk400(clk400), .reset(reset), .init(init), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cam_sel(cam_sel), .i2c_req(i2c_req), .i2c_slave(i2c_slave), .i2c_reg(i2c_reg),
    .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .cam_ready(cam_ready),
    .busy(busy), .error(error)
  );

  always #5 clk400 = ~clk400;

  // per-camera table: index {cam, entry}
  logic [23:0] rom [0:7];
  always @(posedge clk400) tbl_data <= rom[{cam_sel, tbl_addr}];

  int cyc = 0;
  always @(posedge clk400) cyc <= cyc + 1;

  typedef struct {
    logic [0:0]  cam;
    logic [1:0]  ent;
    logic [15:0] rg;
    logic [7:0]  dat;
    logic [7:0]  sl;
    int          at;
  } txn_t;

  txn_t       log_q[$];
  int         done_cyc[$];
  logic [1:0] hist[$];
  logic [1:0] rdy_prev = 2'b00;
  int         req_cycles = 0;
  int         stab_bad = 0;

  int         run_id = 0;
  bit         nack_en = 1'b0;
  logic [2:0] nack_key = 3'd0;
  int         nack_limit = 0;
  bit         hang_en = 1'b0;
  logic [2:0] hang_key = 3'd0;
  int         stray_req = 0;

  always @(negedge clk400) if (i2c_req) req_cycles <= req_cycles + 1;

  always @(negedge clk400) begin
    if (cam_ready !== rdy_prev) begin
      if (cam_ready != 2'b00) hist.push_back(cam_ready);
      rdy_prev <= cam_ready;
    end
  end

  // I2C responder: logs every request, answers 10 cycles later unless hung
  initial begin
    txn_t t;
    int   tries, last_run, stray_seen;
    logic nk;
    tries = 0; last_run = -1; stray_seen = 0;
    i2c_done = 1'b0; i2c_nack = 1'b0;
    @(posedge clk400); #1;
    forever begin
      if (i2c_req) begin
        t.cam = cam_sel; t.ent = tbl_addr; t.rg = i2c_reg; t.dat = i2c_data;
        t.sl = i2c_slave; t.at = cyc;
        log_q.push_back(t);
        if (!(hang_en && {cam_sel, tbl_addr} == hang_key)) begin
          if (last_run != run_id) begin tries = 0; last_run = run_id; end
          nk = 1'b0;
          if (nack_en && {cam_sel, tbl_addr} == nack_key) begin
            tries++;
            nk = (tries <= nack_limit);
          end
          repeat (10) @(posedge clk400);
          #1;
          if (i2c_reg !== t.rg || i2c_data !== t.dat || i2c_slave !== t.sl) stab_bad++;
          i2c_done = 1'b1; i2c_nack = nk;
          @(posedge clk400); #1;
          done_cyc.push_back(cyc);
          i2c_done = 1'b0; i2c_nack = 1'b0;
        end else begin
          @(posedge clk400); #1;
        end
      end else if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        i2c_done = 1'b1; i2c_nack = 1'b0;
        @(posedge clk400); #1;
        i2c_done = 1'b0;
      end else begin
        @(posedge clk400); #1;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk400); #1;
  endtask

  typedef struct {
    string      nm;
    string      seq;      // expected requests, one digit per request: cam*4+entry
    bit         dly;
    bit         nack_en;
    logic [2:0] key;
    int         limit;
    bit         toggle;
    logic       exp_err;
    logic [1:0] exp_rdy;
  } scen_t;

  function automatic scen_t mk(input string nm, input string seq, input bit dly, input bit ne,
                               input logic [2:0] key, input int limit, input bit toggle,
                               input logic exp_err, input logic [1:0] exp_rdy);
    scen_t s;
    s.nm = nm; s.seq = seq; s.dly = dly; s.nack_en = ne; s.key = key; s.limit = limit;
    s.toggle = toggle; s.exp_err = exp_err; s.exp_rdy = exp_rdy;
    return s;
  endfunction

  task automatic run_seq(input scen_t s);
    int         lb, hb, rb, sb, db, lat, n, hn;
    logic [2:0] c3;
    txn_t       t;
    init = 1'b0;
    repeat (3) tick();
    lb = log_q.size(); hb = hist.size(); rb = req_cycles; sb = stab_bad; db = done_cyc.size();
    run_id++;
    init = 1'b1;
    // req visible in the 4th cycle: edge detect, FETCH, LOAD, ISSUE
    lat = 0;
    while (!i2c_req && lat < 20) begin tick(); lat++; end
    chk({s.nm, ".latency"}, 64'(lat), 64'd3);
    chk({s.nm, ".start_clr"}, 64'({error, cam_ready}), 64'd0);
    n = 0;
    while (busy && n < 20000) begin
      tick(); n++;
      if (s.toggle && (n % 7 == 3)) init = ~init;
    end
    chk({s.nm, ".finish"}, 64'(n < 20000), 64'd1);
    repeat (5) tick();
    chk({s.nm, ".no_restart"}, 64'(busy), 64'd0);
    chk({s.nm, ".nreq"}, 64'(log_q.size() - lb), 64'(s.seq.len()));
    chk({s.nm, ".pulses"}, 64'(req_cycles - rb), 64'(s.seq.len()));
    chk({s.nm, ".stable"}, 64'(stab_bad - sb), 64'd0);
    for (int i = 0; i < s.seq.len(); i++) begin
      c3 = 3'(int'(s.seq[i]) - 48);
      if (lb + i < log_q.size()) begin
        t = log_q[lb + i];
        chk($sformatf("%s.req%0d", s.nm, i), {t.cam, t.ent, t.rg, t.dat, t.sl},
            {c3, rom[c3][23:8], rom[c3][7:0], SA});
      end
    end
    chk({s.nm, ".error"}, 64'(error), 64'(s.exp_err));
    chk({s.nm, ".ready"}, 64'(cam_ready), 64'(s.exp_rdy));
    hn = (s.exp_rdy == 2'b11) ? 2 : 1;
    chk({s.nm, ".hist_n"}, 64'(hist.size() - hb), 64'(hn));
    if (hist.size() > hb)     chk({s.nm, ".hist0"}, 64'(hist[hb]), 64'd1);
    if (hn == 2 && hist.size() > hb + 1) chk({s.nm, ".hist1"}, 64'(hist[hb + 1]), 64'd3);
    // 3 cycles to reach the delay, 800 in DELAY, 3 more to the next ISSUE
    if (s.dly && log_q.size() > lb + 4 && done_cyc.size() > db + 3) begin
      chk({s.nm, ".gap_c0"}, 64'(log_q[lb + 1].at - done_cyc[db]), 64'd806);
      chk({s.nm, ".gap_c1"}, 64'(log_q[lb + 4].at - done_cyc[db + 3]), 64'd806);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  scen_t sc [5];
  scen_t rs;

  initial begin
    int lb, rb, n;
    sc[0] = mk("normal",  "01234567",   0, 0, 3'd0, 0,    0, 1'b0, 2'b11);
    sc[1] = mk("delay",   "023467",     1, 0, 3'd0, 0,    0, 1'b0, 2'b11);
    sc[2] = mk("nack2",   "0122234567", 0, 1, 3'd2, 2,    0, 1'b0, 2'b11);
    sc[3] = mk("nackall", "012345555",  0, 1, 3'd5, 1000, 0, 1'b1, 2'b01);
    sc[4] = mk("toggle",  "01234567",   0, 0, 3'd0, 0,    1, 1'b0, 2'b11);
    for (int k = 0; k < 8; k++) rom[k] = {8'h30, 8'(k), 8'hA0 + 8'(k)};

    reset = 1'b1; init = 1'b0;
    repeat (3) tick();
    chk("rst.req",   64'(i2c_req), 64'd0);
    chk("rst.busy",  64'(busy), 64'd0);
    chk("rst.error", 64'(error), 64'd0);
    chk("rst.ready", 64'(cam_ready), 64'd0);
    chk("rst.cam",   64'(cam_sel), 64'd0);
    chk("rst.addr",  64'(tbl_addr), 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("rst.idle", 64'(busy), 64'd0);

    for (int s = 0; s < 5; s++) begin
      if (sc[s].dly) begin rom[1] = 24'hFFFF02; rom[5] = 24'hFFFF02; end
      nack_en = sc[s].nack_en; nack_key = sc[s].key; nack_limit = sc[s].limit;
      run_seq(sc[s]);
      rom[1] = {8'h30, 8'd1, 8'hA1}; rom[5] = {8'h30, 8'd5, 8'hA5};
    end
    nack_en = 1'b0;

    // reset while waiting on cam 1 entry 2, then a stray done, then a clean restart
    hang_en = 1'b1; hang_key = 3'd6;
    init = 1'b0;
    repeat (3) tick();
    lb = log_q.size();
    run_id++;
    init = 1'b1;
    n = 0;
    while (log_q.size() - lb < 7 && n < 2000) begin tick(); n++; end
    chk("rwait.reach", 64'(log_q.size() - lb), 64'd7);
    repeat (3) tick();
    chk("rwait.pre", 64'({busy, cam_ready}), 64'({1'b1, 2'b01}));
    reset = 1'b1;
    tick(); tick();
    chk("rwait.req",   64'(i2c_req), 64'd0);
    chk("rwait.outs",  64'({busy, error, cam_ready}), 64'd0);
    chk("rwait.cam",   64'(cam_sel), 64'd0);
    chk("rwait.addr",  64'(tbl_addr), 64'd0);
    reset = 1'b0; init = 1'b0;
    rb = req_cycles;
    stray_req++;
    repeat (6) tick();
    chk("stray.idle",  64'({busy, error, cam_ready}), 64'd0);
    chk("stray.noreq", 64'(req_cycles - rb), 64'd0);
    hang_en = 1'b0;
    rs = mk("restart", "01234567", 0, 0, 3'd0, 0, 0, 1'b0, 2'b11);
    run_seq(rs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
